// File: rtl/simple_pe.sv
// Signed multiply-accumulate cell with a saturating accumulator and a sticky overflow flag.
// One MAC per clock, no pipelining. Reset is synchronous and active-low.
module simple_pe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_enable,
  input  logic                  i_clear,
  output logic [ACC_WIDTH-1:0]  o_result,
  output logic                  o_overflow
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned SUM_WIDTH  = ACC_WIDTH + 1;

  // Saturation bounds held one bit wider so they compare directly against the sum.
  localparam logic signed [SUM_WIDTH-1:0] ACC_MAX_EXT = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] ACC_MIN_EXT = {2'b11, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         overflow;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [SUM_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic                         overflow_next;

  // Full-precision product and one-bit-wider sum, then clamp to the accumulator range.
  always_comb begin
    prod          = PROD_WIDTH'($signed(i_a)) * PROD_WIDTH'($signed(i_b));
    sum           = SUM_WIDTH'(acc) + SUM_WIDTH'(prod);
    acc_next      = sum[ACC_WIDTH-1:0];
    overflow_next = overflow;
    if (sum > ACC_MAX_EXT) begin
      acc_next      = ACC_MAX_EXT[ACC_WIDTH-1:0];
      overflow_next = 1'b1;
    end else if (sum < ACC_MIN_EXT) begin
      acc_next      = ACC_MIN_EXT[ACC_WIDTH-1:0];
      overflow_next = 1'b1;
    end
  end

  // Reset beats clear beats enable; clear never loads the product.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (i_clear) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (i_enable) begin
      acc      <= acc_next;
      overflow <= overflow_next;
    end
  end

  assign o_result   = acc;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_simple_pe.sv
// Scoreboard bench for simple_pe: directed test-plan steps plus randomized traffic
// checked against an integer reference model of the saturating MAC.
module tb_simple_pe;

  logic        clk;
  logic        i_reset;
  logic [7:0]  i_a;
  logic [7:0]  i_b;
  logic        i_enable;
  logic        i_clear;
  logic [15:0] o_result;
  logic        o_overflow;

  typedef struct {
    int    res;
    bit    ovf;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_acc    = 0;
  bit   m_ovf    = 1'b0;

  simple_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_enable   (i_enable),
    .i_clear    (i_clear),
    .o_result   (o_result),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic with clamping.
  task automatic model_step(input int rst_n, input int en, input int clr,
                            input int a, input int b);
    int s;
    if (rst_n == 0 || clr != 0) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end else if (en != 0) begin
      s = m_acc + a * b;
      if (s > 32767) begin
        m_acc = 32767;
        m_ovf = 1'b1;
      end else if (s < -32768) begin
        m_acc = -32768;
        m_ovf = 1'b1;
      end else begin
        m_acc = s;
      end
    end
  endtask

  // Drive one cycle at the falling edge and queue the expected post-edge outputs.
  task automatic step(input int rst_n, input int en, input int clr, input int a, input int b,
                      input bit xop, input bit use_exp, input int er, input bit eo,
                      input string tag);
    exp_t e;
    @(negedge clk);
    i_reset  = 1'(rst_n);
    i_enable = 1'(en);
    i_clear  = 1'(clr);
    if (xop) begin
      i_a = 'x;
      i_b = 'x;
    end else begin
      i_a = 8'(a);
      i_b = 8'(b);
    end
    model_step(rst_n, en, clr, a, b);
    e.tag = tag;
    if (use_exp) begin
      e.res = er;
      e.ovf = eo;
      m_acc = er;
      m_ovf = eo;
    end else begin
      e.res = m_acc;
      e.ovf = m_ovf;
    end
    exp_q.push_back(e);
  endtask

  task automatic dstep(input int rst_n, input int en, input int clr, input int a, input int b,
                       input int er, input bit eo, input string tag);
    step(rst_n, en, clr, a, b, 1'b0, 1'b1, er, eo, tag);
  endtask

  // Monitor: outputs are valid every cycle, so compare one queued entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ($signed(o_result) != e.res || o_overflow != e.ovf) begin
          failures++;
          $display("FAIL %s: got result=%0d ovf=%0b, expected result=%0d ovf=%0b",
                   e.tag, $signed(o_result), o_overflow, e.res, e.ovf);
        end
      end
    end
  end

  initial begin
    int r, en, clr, rst_n, a, b, pick;
    int budget;
    i_reset = 1'b0; i_enable = 1'b0; i_clear = 1'b0; i_a = '0; i_b = '0;

    dstep(0, 1, 0, 5, 5, 0, 0, "reset0");
    dstep(0, 1, 0, 5, 5, 0, 0, "reset1");

    dstep(1, 1, 0, 3, 4, 12, 0, "acc_3x4");
    dstep(1, 1, 0, -2, 5, 2, 0, "acc_m2x5");
    dstep(1, 1, 0, 7, -1, -5, 0, "acc_7xm1");

    for (int i = 0; i < 3; i++) dstep(1, 0, 0, 11 * i + 1, -9 * i - 3, -5, 0, "hold");
    dstep(1, 1, 1, 10, 10, 0, 0, "clear_with_enable");

    dstep(1, 1, 0, -128, -128, 16384, 0, "possat1");
    dstep(1, 1, 0, -128, -128, 32767, 1, "possat2");
    dstep(1, 1, 0, -128, -128, 32767, 1, "possat3");
    dstep(1, 1, 0, 1, -1, 32766, 1, "possat_dec");

    dstep(1, 0, 1, 0, 0, 0, 0, "clear_a");
    dstep(1, 1, 0, 127, -128, -16256, 0, "negsat1");
    dstep(1, 1, 0, 127, -128, -32512, 0, "negsat2");
    dstep(1, 1, 0, 127, -128, -32768, 1, "negsat3");
    dstep(1, 0, 1, 0, 0, 0, 0, "clear_b");

    dstep(1, 1, 0, 100, 100, 10000, 0, "mid_acc");
    dstep(0, 1, 0, 100, 100, 0, 0, "mid_reset");
    dstep(1, 1, 0, 2, 3, 6, 0, "after_reset");

    // Random traffic, biased toward extreme operands so saturation recurs.
    for (int i = 0; i < 400; i++) begin
      r     = int'($urandom_range(0, 63));
      rst_n = (r == 0) ? 0 : 1;
      clr   = ($urandom_range(0, 15) == 0) ? 1 : 0;
      en    = ($urandom_range(0, 3) != 0) ? 1 : 0;
      pick  = int'($urandom_range(0, 3));
      if (pick == 0) begin
        a = ($urandom_range(0, 1) != 0) ? 127 : -128;
        b = ($urandom_range(0, 1) != 0) ? 127 : -128;
      end else begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
      end
      if (rst_n == 1 && clr == 0 && en == 0 && $urandom_range(0, 1) != 0)
        step(rst_n, en, clr, a, b, 1'b1, 1'b0, 0, 1'b0, "rand_idle_x");
      else
        step(rst_n, en, clr, a, b, 1'b0, 1'b0, 0, 1'b0, "rand");
    end

    @(negedge clk);
    i_enable = 1'b0;
    i_clear  = 1'b0;
    budget   = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_pe.md
# simple_pe

Single multiply-accumulate processing element for the CNN accelerator datapath. Each enabled cycle it multiplies two signed 8-bit operands and adds the product into a signed 16-bit saturating accumulator. The accumulator is exposed as `o_result`, and a sticky flag reports any saturation. It is the basic cell replicated in the systolic/array layers and is driven directly by the array controller.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: operand width, signed two's complement.
- `ACC_WIDTH`, default 16: accumulator/result width, signed; must be ≥ 2*DATA_WIDTH.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `i_reset`  input  1  reset; synchronous and active-low. Despite the name, 0 resets.
- `i_a`  input  DATA_WIDTH  signed operand A.
- `i_b`  input  DATA_WIDTH  signed operand B.
- `i_enable`  input  1  when 1, perform one MAC step this cycle.
- `i_clear`  input  1  when 1, zero the accumulator and overflow flag this cycle.
- `o_result`  output  ACC_WIDTH  signed accumulator value, registered.
- `o_overflow`  output  1  sticky saturation flag, registered.

## Operation

- Product: p = signed(i_a) * signed(i_b), full 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH+1.
- Sum: s = sign-extended acc + p, computed in ACC_WIDTH+1 bits so no intermediate wrap.
- Saturation bounds are ACC_MAX = 2^(ACC_WIDTH-1)-1 (32767) and ACC_MIN = -2^(ACC_WIDTH-1) (-32768).
  - If s > ACC_MAX, acc ← ACC_MAX and overflow ← 1.
  - If s < ACC_MIN, acc ← ACC_MIN and overflow ← 1.
  - Otherwise acc ← s; overflow holds its value.
- Overflow is sticky. Only clear or reset returns it to 0.
- Per-edge priority, highest first:
  1. Reset active (i_reset=0): acc ← 0, overflow ← 0.
  2. i_clear=1: acc ← 0, overflow ← 0. The operands are ignored even if i_enable=1, so clear does not load a*b.
  3. i_enable=1: MAC step as above.
  4. Otherwise: acc and overflow hold.
- Once saturated, further enabled steps keep computing from the saturated value. For example, ACC_MAX plus a negative product decreases normally.
- Inputs with X/Z while i_enable=0 and i_clear=0 must not affect state.
- No internal pipelining. The multiply and add are combinational within one cycle.

## Timing

- o_result = acc and o_overflow = overflow, both driven directly from registers with no combinational input-to-output path.
- Reset values: o_result = 0, o_overflow = 0, visible after the first rising edge with i_reset=0.
- Latency is 1 cycle. Operands and controls sampled at edge N appear in the outputs after edge N.
- Back-to-back enables are allowed every cycle. Throughput is one MAC per clock.
- Reset mid-accumulation takes effect at the next edge regardless of i_enable or i_clear. After reset is released, accumulation restarts from 0.
- When i_clear and i_enable are both asserted at an edge, the result is 0 and overflow is 0.
- There is no handshake. The controller owns i_enable/i_clear sequencing.

## Test plan

- Reset: hold i_reset=0 for 2 cycles with i_enable=1, i_a=5, i_b=5. Required: o_result=0 and o_overflow=0. Release reset.
- Basic accumulate: enable with (3,4), then (-2,5), then (7,-1). Required after each edge: o_result = 12, then 2, then -5; o_overflow=0 throughout.
- Hold and clear: set i_enable=0 for 3 cycles with changing operands. Required: o_result stays -5. Then assert i_clear=1 together with i_enable=1 and (10,10). Required: o_result=0, o_overflow=0.
- Positive saturation: from 0, enable (-128,-128) three times. Required: o_result = 16384, then 32767 with o_overflow=1, then still 32767 with o_overflow=1. Next, enable (1,-1). Required: o_result=32766 and o_overflow still 1.
- Negative saturation: clear, then enable (127,-128) three times. Required: o_result = -16256, then -32512, then -32768 with o_overflow=1. Then clear. Required: o_result=0, o_overflow=0.
- Reset mid-operation: accumulate (100,100) to 10000, then drive i_reset=0 for 1 cycle with i_enable=1. Required: o_result=0. After release, enable (2,3). Required: o_result=6.
